mcycle_unit: RTL and testbench

- Iterative multi-cycle multiply/divide unit in the Execute stage, directly downstream of the E pipeline register.
- Consumes MCycleStartE, MCycleOpE and the forwarded Execute operands.
- Produces the RV32M result pair and the Busy signal that stalls the front-end pipeline registers until the result is ready.
- One bit of multiplier or quotient is resolved per cycle.

---
 rtl/mcycle_unit_pkg.sv | 18 +
 rtl/mcycle_unit.sv | 133 +++++++++++++
 tb/tb_mcycle_unit.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/mcycle_unit_pkg.sv
// Shared multi-cycle multiply/divide definitions: opcodes, FSM states, default widths.
package mcycle_unit_pkg;

    localparam int unsigned MCYCLE_WIDTH = 32;
    localparam int unsigned MCYCLE_CNT_W = 6;

    localparam logic [1:0] MCYCLE_OP_SMUL = 2'b00;
    localparam logic [1:0] MCYCLE_OP_UMUL = 2'b01;
    localparam logic [1:0] MCYCLE_OP_SDIV = 2'b10;
    localparam logic [1:0] MCYCLE_OP_UDIV = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/mcycle_unit.sv
// Iterative RV32M multiply/divide: one multiplier or quotient bit per cycle, stalls the
// front end through Busy until the result pair is written.
module mcycle_unit
    import mcycle_unit_pkg::*;
#(
    parameter int unsigned WIDTH = MCYCLE_WIDTH,
    parameter int unsigned CNT_W = MCYCLE_CNT_W
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             Start,
    input  logic [1:0]       MCycleOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy
);

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic               is_div;
    logic               res_neg;
    logic               rem_neg;
    logic               div_zero;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   op1_q;
    logic [2*WIDTH-1:0] prod;

    logic               s1;
    logic               s2;
    logic [WIDTH-1:0]   abs1;
    logic [WIDTH-1:0]   abs2;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   rem_sub;
    logic               no_borrow;
    logic [2*WIDTH-1:0] prod_nx;
    logic [2*WIDTH-1:0] prod_neg;
    logic [WIDTH-1:0]   res1_nx;
    logic [WIDTH-1:0]   res2_nx;
    logic               last;

    // Busy follows Start in IDLE so the stall lands in the same cycle as the request.
    assign Busy = RESETn & ((state == S_IDLE) ? Start : (state == S_COMPUTE));

    assign s1   = ~MCycleOp[0] & Operand1[WIDTH-1];
    assign s2   = ~MCycleOp[0] & Operand2[WIDTH-1];
    assign abs1 = s1 ? WIDTH'(-Operand1) : Operand1;
    assign abs2 = s2 ? WIDTH'(-Operand2) : Operand2;
    assign last = (count == CNT_W'(WIDTH - 1));

    // One iteration: shift-add for multiply, restoring trial-subtract for divide.
    always_comb begin
        mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, a};
        // Shifted remainder needs WIDTH+1 bits when the divisor exceeds half range.
        no_borrow = (prod[2*WIDTH-1:WIDTH-1] >= {1'b0, a});
        rem_sub   = prod[2*WIDTH-2:WIDTH-1] - a;
        if (is_div) begin
            if (no_borrow) prod_nx = {rem_sub, prod[WIDTH-2:0], 1'b1};
            else           prod_nx = {prod[2*WIDTH-2:0], 1'b0};
        end else if (prod[0]) begin
            prod_nx = {mul_sum, prod[WIDTH-1:1]};
        end else begin
            prod_nx = {1'b0, prod[2*WIDTH-1:1]};
        end
    end

    // Sign fix-up and special cases applied on the final write.
    always_comb begin
        prod_neg = (2*WIDTH)'(-prod_nx);
        res1_nx  = prod_nx[WIDTH-1:0];
        res2_nx  = prod_nx[2*WIDTH-1:WIDTH];
        if (!is_div) begin
            if (res_neg) {res2_nx, res1_nx} = prod_neg;
        end else if (div_zero) begin
            res1_nx = '1;
            res2_nx = op1_q;
        end else begin
            if (res_neg) res1_nx = WIDTH'(-prod_nx[WIDTH-1:0]);
            if (rem_neg) res2_nx = WIDTH'(-prod_nx[2*WIDTH-1:WIDTH]);
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state    <= S_IDLE;
            count    <= '0;
            is_div   <= 1'b0;
            res_neg  <= 1'b0;
            rem_neg  <= 1'b0;
            div_zero <= 1'b0;
            a        <= '0;
            op1_q    <= '0;
            prod     <= '0;
            Result1  <= '0;
            Result2  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        is_div   <= MCycleOp[1];
                        res_neg  <= s1 ^ s2;
                        rem_neg  <= s1;
                        div_zero <= MCycleOp[1] & (Operand2 == '0);
                        op1_q    <= Operand1;
                        count    <= '0;
                        if (MCycleOp[1]) begin
                            a    <= abs2;
                            prod <= {{WIDTH{1'b0}}, abs1};
                        end else begin
                            a    <= abs1;
                            prod <= {{WIDTH{1'b0}}, abs2};
                        end
                        state <= S_COMPUTE;
                    end
                end
                S_COMPUTE: begin
                    prod  <= prod_nx;
                    count <= count + CNT_W'(1);
                    if (last) begin
                        Result1 <= res1_nx;
                        Result2 <= res2_nx;
                        state   <= S_DONE;
                    end
                end
                // The issuing instruction is still in E here; never restart from DONE.
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mcycle_unit.sv
// Directed-vector bench for mcycle_unit: latency, RV32M results, special cases, reset abort.
module tb_mcycle_unit;
    import mcycle_unit_pkg::*;

    logic        CLK;
    logic        RESETn;
    logic        Start;
    logic [1:0]  MCycleOp;
    logic [31:0] Operand1;
    logic [31:0] Operand2;
    logic [31:0] Result1;
    logic [31:0] Result2;
    logic        Busy;

    int total;
    int bad;

    mcycle_unit dut (
        .CLK      (CLK),
        .RESETn   (RESETn),
        .Start    (Start),
        .MCycleOp (MCycleOp),
        .Operand1 (Operand1),
        .Operand2 (Operand2),
        .Result1  (Result1),
        .Result2  (Result2),
        .Busy     (Busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the edge that leaves DONE.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] x,
                          input logic [31:0] y, input logic hold,
                          input logic [31:0] e1, input logic [31:0] e2);
        int n;
        n        = 0;
        Start    = 1'b1;
        MCycleOp = op;
        Operand1 = x;
        Operand2 = y;
        @(negedge CLK);
        while (Busy && n < 100) begin
            n++;
            @(posedge CLK);
            #1;
            if (!hold) Start = 1'b0;
            @(negedge CLK);
        end
        check({tag, " busy cycles"}, 32'(n), 32'd33);
        check({tag, " result1"}, Result1, e1);
        check({tag, " result2"}, Result2, e2);
        @(posedge CLK);
        #1;
        if (!hold) Start = 1'b0;
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        RESETn   = 1'b0;
        Start    = 1'b0;
        MCycleOp = MCYCLE_OP_UMUL;
        Operand1 = '0;
        Operand2 = '0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset busy", {31'b0, Busy}, 32'd0);
        check("reset result1", Result1, 32'd0);
        check("reset result2", Result2, 32'd0);
        RESETn = 1'b1;
        @(posedge CLK);
        #1;

        run_op("umul max", MCYCLE_OP_UMUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1,
               32'h0000_0001, 32'hFFFF_FFFE);
        Start = 1'b0;
        @(posedge CLK);
        #1;
        run_op("smul -3*5", MCYCLE_OP_SMUL, 32'hFFFF_FFFD, 32'd5, 1'b0,
               32'hFFFF_FFF1, 32'hFFFF_FFFF);
        run_op("umul fffffffd*5", MCYCLE_OP_UMUL, 32'hFFFF_FFFD, 32'd5, 1'b0,
               32'hFFFF_FFF1, 32'h0000_0004);
        run_op("smul min*-1", MCYCLE_OP_SMUL, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0,
               32'h8000_0000, 32'h0000_0000);
        run_op("sdiv -7/2", MCYCLE_OP_SDIV, 32'hFFFF_FFF9, 32'd2, 1'b0,
               32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_op("udiv 100/7", MCYCLE_OP_UDIV, 32'd100, 32'd7, 1'b0, 32'd14, 32'd2);
        run_op("udiv 100/0", MCYCLE_OP_UDIV, 32'd100, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd100);
        run_op("sdiv 100/0", MCYCLE_OP_SDIV, 32'd100, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd100);
        run_op("sdiv -7/0", MCYCLE_OP_SDIV, 32'hFFFF_FFF9, 32'd0, 1'b0,
               32'hFFFF_FFFF, 32'hFFFF_FFF9);
        run_op("sdiv overflow", MCYCLE_OP_SDIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0,
               32'h8000_0000, 32'h0000_0000);
        run_op("udiv big divisor", MCYCLE_OP_UDIV, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0,
               32'h0000_0001, 32'h7FFF_FFFE);

        // Back-to-back: Start never drops, new operands arrive right after DONE.
        run_op("b2b first", MCYCLE_OP_UMUL, 32'd6, 32'd7, 1'b1, 32'd42, 32'd0);
        run_op("b2b second", MCYCLE_OP_UDIV, 32'd1000, 32'd9, 1'b0, 32'd111, 32'd1);

        // Reset mid-divide: Busy and results must clear without waiting for an edge.
        Start    = 1'b1;
        MCycleOp = MCYCLE_OP_UDIV;
        Operand1 = 32'd500;
        Operand2 = 32'd3;
        @(posedge CLK);
        #1;
        Start = 1'b0;
        repeat (9) @(posedge CLK);
        #2;
        check("pre-abort busy", {31'b0, Busy}, 32'd1);
        Start  = 1'b1;
        RESETn = 1'b0;
        #1;
        check("abort busy", {31'b0, Busy}, 32'd0);
        check("abort result1", Result1, 32'd0);
        check("abort result2", Result2, 32'd0);
        @(posedge CLK);
        #1;
        Start  = 1'b0;
        RESETn = 1'b1;
        @(posedge CLK);
        #1;
        run_op("post-abort udiv", MCYCLE_OP_UDIV, 32'd100, 32'd7, 1'b0, 32'd14, 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
